interrupt_arbiter: RTL and testbench
====================================

Name: interrupt_arbiter

Overview:
- Owns the machine/supervisor interrupt-pending state (mip view) for the core.
- Synchronizes and latches the 12 interrupt source lines, and qualifies them against mie, mideleg, current privilege and the mstatus global enables.
- Selects one cause by the fixed privileged-spec priority.
- Presents that cause to the commit stage with a req/ack handshake, then clears edge-type pending bits once the trap is taken.

Parameters:
- EDGE_MASK, 12'h0aa: bit=1 means the source is edge-triggered (SSI/MSI/STI/MTI by default); bit=0 means level.
- HOLDOFF, 2: idle cycles after an ack before a new request may assert (1..15).

Ports:
- i_clk  input  1  core clock
- i_rst_n  input  1  asynchronous active-low reset
- i_irq  input  12  raw asynchronous source lines, bit index = cause number
- i_csr_we  input  1  CSR write to mip this cycle
- i_csr_wdata  input  12  mip write data
- i_inte  input  12  mie
- i_mideleg  input  12  delegation mask
- i_priv  input  2  current privilege (0=U, 1=S, 3=M)
- i_mie  input  1  mstatus.MIE
- i_sie  input  1  mstatus.SIE
- i_ack  input  1  commit has taken the presented interrupt
- o_intp  output  12  pending register (mip read value)
- o_req  output  1  interrupt request to commit
- o_cause  output  4  cause number of o_req
- o_to_s  output  1  request targets S-mode (delegated)

Behaviour:
- Reset is asynchronous on i_rst_n low. While reset is asserted and after release:
  - o_intp, o_req, o_cause and o_to_s are 0.
  - The synchronizer flops and the edge-history flops are 0.
  - The FSM is in IDLE and the holdoff counter is 0.
- Reset asserted mid-request drops o_req immediately.
- Synchronizer: 2-flop stage per bit, giving sync[11:0].
- Level bit update: pend <= sync. CSR writes to level bits are ignored. Latency is a pin change at edge N visible on o_intp at N+3.
- Edge bit update:
  - Set on a sync rising edge (sync & ~prev).
  - Cleared by i_ack for the frozen cause.
  - Written by i_csr_we (pend <= wdata).
  - Set beats both clear and CSR write in the same cycle. Ack-clear and CSR write in the same cycle: CSR write wins, unless a set is also present.
- Bits 0, 2, 4, 6, 8, 10 are hardwired 0.
- Qualification:
  - M-target = pend & inte & ~mideleg; enabled when priv!=M or i_mie.
  - S-target = pend & inte & mideleg; enabled when priv==U, or priv==S and i_sie; never enabled in M.
- Priority: M-target is considered before S-target. Within each group the order is 11, 3, 7, 9, 1, 5. The winner is a combinational pick.
- FSM:
  - IDLE → ARMED when a qualified winner exists and holdoff==0. The winner is latched into o_cause/o_to_s and o_req=1 next cycle.
  - ARMED: cause and target stay frozen; a later higher-priority arrival does not preempt.
    - i_ack=1 → HOLD: o_req=0 next cycle, edge bit cleared, holdoff loaded with HOLDOFF.
    - Frozen cause no longer qualified (pend cleared, mie/deleg/priv/enable change) and no ack → IDLE: o_req=0 next cycle (retract).
    - Ack and disqualification in the same cycle: ack wins.
  - HOLD: holdoff decrements each cycle; at 0 → IDLE.
- i_ack while not ARMED is ignored.
- o_req is a registered output. Qualification-to-req latency is 1 cycle.

Test Plan:
- MTI edge path:
  - Stimulus: reset, priv=M, mie=1, inte=12'h080, raise i_irq[7] at cycle 10.
  - Response: o_intp[7]=1 at cycle 13; o_req=1, o_cause=7, o_to_s=0 at cycle 14.
  - Stimulus: ack at cycle 16.
  - Response: o_req=0 and o_intp[7]=0 at cycle 17; no new request before cycle 19.
- Priority:
  - Stimulus: MEI(11), MTI(7), SEI(9) pending together, none delegated, priv=S.
  - Response: cause 11; after ack with 11 held low, next cause 7, then 9.
- Delegation:
  - Stimulus: mideleg=12'h200, SEI pending, priv=M.
  - Response: no req. Switch priv=S, sie=1 → req cause 9, o_to_s=1. Clear sie before ack → retract, o_req=0 next cycle.
- Freeze:
  - Stimulus: ARMED with cause 5 (STI delegated, priv=U); assert MEI.
  - Response: o_cause stays 5 until ack, then MEI is presented after holdoff.
- CSR vs edge:
  - Stimulus: same cycle, csr_we with wdata[3]=0 and sync rising edge on bit 3.
  - Response: o_intp[3]=1.
  - Stimulus: csr_we wdata=12'h800 with level source 11 low.
  - Response: o_intp[11] stays 0.
- Reset mid-request:
  - Stimulus: drop i_rst_n while o_req=1.
  - Response: o_req=0 and o_intp=0 immediately; after release, no req until a source edge re-occurs.

Source files
------------

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: syncs raw sources, owns mip state, picks one cause
// and hands it to commit with a req/ack handshake plus post-ack holdoff.
module interrupt_arbiter #(
  parameter logic [11:0] EDGE_MASK = 12'h0aa,
  parameter int unsigned HOLDOFF   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_irq,
  input  logic        i_csr_we,
  input  logic [11:0] i_csr_wdata,
  input  logic [11:0] i_inte,
  input  logic [11:0] i_mideleg,
  input  logic [1:0]  i_priv,
  input  logic        i_mie,
  input  logic        i_sie,
  input  logic        i_ack,
  output logic [11:0] o_intp,
  output logic        o_req,
  output logic [3:0]  o_cause,
  output logic        o_to_s
);

  localparam logic [11:0] IMPL  = 12'haaa;
  localparam logic [11:0] EMASK = EDGE_MASK & IMPL;
  localparam logic [11:0] LMASK = ~EDGE_MASK & IMPL;
  localparam logic [3:0]  HLD   = 4'(HOLDOFF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic        arm;

  logic [11:0] sync1;
  logic [11:0] sync;
  logic [11:0] prev;
  logic [11:0] pend;
  logic [11:0] pend_n;
  logic [11:0] edge_n;
  logic [11:0] rise;
  logic [11:0] clr;

  logic        m_en;
  logic        s_en;
  logic [11:0] m_cand;
  logic [11:0] s_cand;
  logic [4:0]  m_pick;
  logic [4:0]  s_pick;
  logic        win_any;
  logic [3:0]  win_cause;
  logic        win_s;
  logic        frozen_ok;

  // Fixed order 11,3,7,9,1,5; returns {valid, cause}
  function automatic logic [4:0] pick(input logic [11:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c[11])     r = {1'b1, 4'd11};
    else if (c[3]) r = {1'b1, 4'd3};
    else if (c[7]) r = {1'b1, 4'd7};
    else if (c[9]) r = {1'b1, 4'd9};
    else if (c[1]) r = {1'b1, 4'd1};
    else if (c[5]) r = {1'b1, 4'd5};
    return r;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync  <= '0;
      prev  <= '0;
    end else begin
      sync1 <= i_irq;
      sync  <= sync1;
      prev  <= sync;
    end
  end

  always_comb begin
    rise = sync & ~prev & EMASK;
    clr  = '0;
    if (state == ARMED && i_ack)
      clr = 12'd1 << o_cause;
    edge_n = i_csr_we ? i_csr_wdata : (pend & ~clr);
    edge_n = (edge_n | rise) & EMASK;
    pend_n = edge_n | (sync & LMASK);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pend <= '0;
    else          pend <= pend_n;
  end

  always_comb begin
    m_en   = (i_priv != 2'b11) || i_mie;
    s_en   = (i_priv == 2'b00) ||
             (i_priv == 2'b01 && i_sie);
    m_cand = pend & i_inte & ~i_mideleg;
    s_cand = pend & i_inte & i_mideleg;
    if (!m_en) m_cand = '0;
    if (!s_en) s_cand = '0;
    m_pick = pick(m_cand);
    s_pick = pick(s_cand);
    win_any   = m_pick[4] || s_pick[4];
    win_s     = !m_pick[4];
    win_cause = m_pick[4] ? m_pick[3:0] : s_pick[3:0];
    frozen_ok = o_to_s ? s_cand[o_cause] : m_cand[o_cause];
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    arm     = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_any && cnt == 4'd0) begin
          state_n = ARMED;
          arm     = 1'b1;
        end
      end
      ARMED: begin
        if (i_ack) begin
          state_n = HOLD;
          cnt_n   = HLD;
        end else if (!frozen_ok) begin
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (cnt <= 4'd1) begin
          cnt_n   = 4'd0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      o_req   <= 1'b0;
      o_cause <= 4'd0;
      o_to_s  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      o_req <= (state_n == ARMED);
      if (arm) begin
        o_cause <= win_cause;
        o_to_s  <= win_s;
      end
    end
  end

  assign o_intp = pend;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed scenarios plus random traffic, checked against a
// rule-level model of pending state and arbitration.
module tb_interrupt_arbiter;

  localparam logic [11:0] EDGE = 12'h0aa;
  localparam int          HOLD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] irq;
  logic        csr_we;
  logic [11:0] wdata;
  logic [11:0] inte;
  logic [11:0] mideleg;
  logic [1:0]  priv;
  logic        mie;
  logic        sie;
  logic        ack;
  logic [11:0] intp;
  logic        req;
  logic [3:0]  cause;
  logic        to_s;

  int tests = 0;
  int fails = 0;

  int order [6] = '{11, 3, 7, 9, 1, 5};

  logic [11:0] m_s1, m_s2, m_prev, m_pend;
  bit          m_armed;
  int          m_hold;
  logic [3:0]  m_cause;
  bit          m_to_s;

  interrupt_arbiter #(.EDGE_MASK(EDGE), .HOLDOFF(HOLD)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_irq      (irq),
    .i_csr_we   (csr_we),
    .i_csr_wdata(wdata),
    .i_inte     (inte),
    .i_mideleg  (mideleg),
    .i_priv     (priv),
    .i_mie      (mie),
    .i_sie      (sie),
    .i_ack      (ack),
    .o_intp     (intp),
    .o_req      (req),
    .o_cause    (cause),
    .o_to_s     (to_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_prev = '0; m_pend = '0;
    m_armed = 0; m_hold = 0; m_cause = '0; m_to_s = 0;
  endtask

  task automatic m_step();
    logic [11:0] np, mc, sc;
    bit v, men, sen, ok;
    int w;
    bit ws;
    men = (priv != 2'd3) || mie;
    sen = (priv == 2'd0) || (priv == 2'd1 && sie);
    mc = men ? (m_pend & inte & ~mideleg) : 12'h0;
    sc = sen ? (m_pend & inte & mideleg) : 12'h0;
    np = '0;
    for (int b = 1; b < 12; b += 2) begin
      if (!EDGE[b]) begin
        np[b] = m_s2[b];
      end else begin
        v = m_pend[b];
        if (m_armed && ack && int'(m_cause) == b) v = 0;
        if (csr_we) v = wdata[b];
        if (m_s2[b] && !m_prev[b]) v = 1;
        np[b] = v;
      end
    end
    if (m_armed) begin
      ok = m_to_s ? sc[m_cause] : mc[m_cause];
      if (ack) begin
        m_armed = 0;
        m_hold  = HOLD;
      end else if (!ok) begin
        m_armed = 0;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      w = -1; ws = 0;
      foreach (order[i]) if (w < 0 && mc[order[i]]) w = order[i];
      foreach (order[i])
        if (w < 0 && sc[order[i]]) begin w = order[i]; ws = 1; end
      if (w >= 0) begin
        m_armed = 1;
        m_cause = 4'(w);
        m_to_s  = ws;
      end
    end
    m_prev = m_s2;
    m_s2   = m_s1;
    m_s1   = irq;
    m_pend = np;
  endtask

  task automatic tick();
    if (rst_n) m_step();
    @(posedge clk);
    #1;
    chk("model_intp", 32'(intp), 32'(m_pend));
    chk("model_req", 32'(req), 32'(m_armed));
    chk("model_cause", 32'(cause), 32'(m_cause));
    chk("model_to_s", 32'(to_s), 32'(m_to_s));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!req && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(req), 32'd1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; csr_we = 0; wdata = '0;
    inte = '0; mideleg = '0; priv = 2'd3; mie = 0; sie = 0;
    ack = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_intp", 32'(intp), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_cause", 32'(cause), 32'd0);
    chk("rst_to_s", 32'(to_s), 32'd0);
    rst_n = 1'b1;

    // MTI edge path with exact cycle latencies
    mie = 1; inte = 12'h080;
    ticks(3);
    irq[7] = 1'b1;
    ticks(2);
    chk("mti_intp_early", 32'(intp[7]), 32'd0);
    tick();
    chk("mti_intp_n3", 32'(intp[7]), 32'd1);
    chk("mti_req_n3", 32'(req), 32'd0);
    tick();
    chk("mti_req_n4", 32'(req), 32'd1);
    chk("mti_cause", 32'(cause), 32'd7);
    chk("mti_to_s", 32'(to_s), 32'd0);
    ticks(2);
    do_ack();
    chk("mti_req_ack", 32'(req), 32'd0);
    chk("mti_intp_ack", 32'(intp[7]), 32'd0);
    tick();
    chk("mti_hold1", 32'(req), 32'd0);
    tick();
    chk("mti_hold2", 32'(req), 32'd0);
    irq[7] = 1'b0;
    ticks(4);

    // Priority among M-targets in S-mode
    priv = 2'd1; mie = 0; inte = 12'ha80; mideleg = '0;
    irq[11] = 1; irq[9] = 1; irq[7] = 1;
    wait_req("pri_wait1");
    chk("pri_first", 32'(cause), 32'd11);
    irq[11] = 0;
    do_ack();
    wait_req("pri_wait2");
    chk("pri_second", 32'(cause), 32'd7);
    do_ack();
    wait_req("pri_wait3");
    chk("pri_third", 32'(cause), 32'd9);
    irq[9] = 0;
    do_ack();
    irq[7] = 0;
    ticks(6);
    chk("pri_drain", 32'(req), 32'd0);

    // Delegation: masked in M, taken in S, retracted on sie drop
    priv = 2'd3; mie = 1; sie = 0;
    inte = 12'h200; mideleg = 12'h200; irq[9] = 1;
    ticks(6);
    chk("deleg_m_none", 32'(req), 32'd0);
    priv = 2'd1; sie = 1;
    wait_req("deleg_wait");
    chk("deleg_cause", 32'(cause), 32'd9);
    chk("deleg_to_s", 32'(to_s), 32'd1);
    sie = 0;
    tick();
    chk("deleg_retract", 32'(req), 32'd0);
    irq[9] = 0; mideleg = '0;
    ticks(5);

    // Freeze: armed STI not preempted by MEI
    priv = 2'd0; mideleg = 12'h020; inte = 12'h820; irq[5] = 1;
    wait_req("frz_wait");
    chk("frz_cause5", 32'(cause), 32'd5);
    chk("frz_to_s", 32'(to_s), 32'd1);
    irq[11] = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("frz_hold_cause", 32'(cause), 32'd5);
    end
    do_ack();
    chk("frz_ack_req", 32'(req), 32'd0);
    wait_req("frz_wait_mei");
    chk("frz_mei", 32'(cause), 32'd11);
    chk("frz_mei_to_s", 32'(to_s), 32'd0);
    irq[11] = 0;
    do_ack();
    irq[5] = 0;
    ticks(6);

    // CSR write vs edge set, and CSR write to a level bit
    inte = '0; mideleg = '0; priv = 2'd3;
    irq[3] = 1;
    ticks(2);
    csr_we = 1; wdata = 12'h000;
    tick();
    csr_we = 0;
    chk("csr_set_wins", 32'(intp[3]), 32'd1);
    csr_we = 1; wdata = 12'h800;
    tick();
    csr_we = 0;
    chk("csr_level_ign", 32'(intp[11]), 32'd0);
    irq[3] = 0;
    ticks(4);

    // Reset in the middle of a request
    mie = 1; inte = 12'h080; irq[7] = 1;
    wait_req("rst_wait");
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rstm_req", 32'(req), 32'd0);
    chk("rstm_intp", 32'(intp), 32'd0);
    irq[7] = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ticks(6);
    chk("rstm_no_req", 32'(req), 32'd0);
    irq[7] = 1;
    wait_req("rstm_reedge");
    chk("rstm_cause", 32'(cause), 32'd7);
    do_ack();
    irq[7] = 0;
    ticks(4);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0)
        irq[2 * $urandom_range(5) + 1] ^= 1'b1;
      if ($urandom_range(39) == 0) inte = 12'($urandom);
      if ($urandom_range(59) == 0) mideleg = 12'($urandom);
      if ($urandom_range(29) == 0) begin
        case ($urandom_range(2))
          0: priv = 2'd0;
          1: priv = 2'd1;
          default: priv = 2'd3;
        endcase
      end
      if ($urandom_range(19) == 0) mie = 1'($urandom);
      if ($urandom_range(19) == 0) sie = 1'($urandom);
      ack = (req && $urandom_range(2) == 0) ||
            ($urandom_range(15) == 0);
      csr_we = ($urandom_range(24) == 0);
      wdata  = 12'($urandom);
      tick();
    end
    ack = 0; csr_we = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
